// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity constants and parity helper.
// Combinational helpers only; no latency.
// No flow control lives here; both uart_tx and uart_rx import this package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    // Widest data word the frame format supports; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int UART_MAX_SIZE = 9;

    // Parity bit for a data word: even parity is the XOR of the bits, odd is its inverse.
    function automatic logic uart_parity(input logic [UART_MAX_SIZE-1:0] data,
                                         input logic                     ptype);
        return (ptype == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel word handshake into the UART transmitter, with the per-frame parity controls.
// No latency; pure signal bundle.
// tx_ready is driven by the transmitter; a word moves on tx_valid && tx_ready at a clock edge.
interface uart_tx_if #(
    parameter int UART_SIZE = 8
);
    logic [UART_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 parity_enable;
    logic                 parity_type;

    modport master (
        output tx_data,
        output tx_valid,
        output parity_enable,
        output parity_type,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  parity_enable,
        input  parity_type,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, UART_SIZE data bits LSB first, optional parity, one stop bit.
// Frame lasts 2 + UART_SIZE + parity baud_tick periods after the accept edge; all outputs registered.
// tx_ready only in IDLE (and with CTS high when UART_TX_CTS_EN is defined); tx_valid ignored while busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int UART_SIZE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    output logic       phase_accum_reset,
    input  logic       CTS,
    output logic       TX,
    output logic       busy,
    output logic       tx_done,
    uart_tx_if.slave   bus
);

    localparam int                CNT_W    = $clog2(UART_SIZE);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(UART_SIZE - 1);

    tx_state_t            state_q, state_d;
    logic [UART_SIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 par_rst_q, par_rst_d;

    logic                 ready;
    logic                 accept;

`ifdef UART_TX_CTS_EN
    // A new frame may only begin while the peer signals clear-to-send; a frame
    // already under way is never interrupted by CTS.
    assign ready = (state_q == IDLE) && CTS;
`else
    logic cts_unused;
    assign cts_unused = CTS;
    assign ready      = (state_q == IDLE);
`endif

    assign accept       = bus.tx_valid && ready;
    assign bus.tx_ready = ready;

    assign TX                = tx_q;
    assign busy              = busy_q;
    assign tx_done           = done_q;
    assign phase_accum_reset = par_rst_q;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        par_rst_d = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // baud_tick is deliberately not looked at here: the start bit
                // period begins at the accept edge, not at a stray tick.
                if (accept) begin
                    shift_d   = bus.tx_data;
                    par_en_d  = bus.parity_enable;
                    par_bit_d = uart_parity(UART_MAX_SIZE'(bus.tx_data), bus.parity_type);
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    par_rst_d = 1'b1;
                end
            end

            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (cnt_q != LAST_BIT) begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        cnt_d   = cnt_q + 1'b1;
                    end else if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end
            end

            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end

            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Frame state and registered outputs; reset aborts any frame with the line held high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            par_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            par_rst_q <= par_rst_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames from the test plan plus randomized frames,
// checked against a frame model built from the bit-level frame definition.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int W = 8;

    typedef bit bitq_t[$];

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic baud_tick = 1'b0;
    logic CTS       = 1'b1;
    logic phase_accum_reset;
    logic TX;
    logic busy;
    logic tx_done;

    uart_tx_if #(.UART_SIZE(W)) bus ();

    uart_tx #(.UART_SIZE(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .baud_tick         (baud_tick),
        .phase_accum_reset (phase_accum_reset),
        .CTS               (CTS),
        .TX                (TX),
        .busy              (busy),
        .tx_done           (tx_done),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int par_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally output pulses seen there.
    task automatic step();
        @(negedge clk);
        if (tx_done === 1'b1) done_seen++;
        if (phase_accum_reset === 1'b1) par_seen++;
    endtask

    // Reference line sequence for one frame, one entry per bit period.
    function automatic bitq_t build_frame(input logic [W-1:0] d, input bit pen, input bit pty);
        bitq_t q;
        int ones;
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
        if (pen) begin
            ones = $countones(d);
            // Even: total ones including parity is even; odd: total is odd.
            if (pty) q.push_back((ones % 2) == 1);
            else     q.push_back((ones % 2) == 0);
        end
        q.push_back(1'b1);
        return q;
    endfunction

    // Send one frame, driving baud ticks every 'per' clocks. Caller is at a falling edge.
    // hold: leave tx_valid high (garbage data) so the next call chains back-to-back.
    // abort_bit: frame bit index at whose midpoint reset is pulsed (-1 = none).
    task automatic send_frame(input logic [W-1:0] d, input bit pen, input bit pty,
                              input int per, input bit tick_acc, input bit hold,
                              input int abort_bit, input bit cts_drop);
        bitq_t exp;
        int    waited;
        exp       = build_frame(d, pen, pty);
        done_seen = 0;
        par_seen  = 0;
        bus.tx_data       = d;
        bus.parity_enable = pen;
        bus.parity_type   = pty;
        bus.tx_valid      = 1'b1;
        waited = 0;
        while (bus.tx_ready !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (bus.tx_ready !== 1'b1) begin
            check("accept_timeout", bus.tx_ready, 1);
            bus.tx_valid = 1'b0;
            return;
        end
        baud_tick = tick_acc;
        step();
        baud_tick = 1'b0;
        if (!hold) bus.tx_valid = 1'b0;
        // Inputs changing mid-frame must not affect the frame in flight.
        bus.tx_data       = W'($urandom);
        bus.parity_enable = 1'($urandom);
        bus.parity_type   = 1'($urandom);
        check("start_tx", TX, 0);
        check("start_busy", busy, 1);
        check("start_ready", bus.tx_ready, 0);
        check("par_rst_on_accept", phase_accum_reset, 1);
        for (int b = 0; b < exp.size(); b++) begin
            repeat (per / 2) step();
            check($sformatf("bit%0d_d%0h", b, d), TX, exp[b]);
            check($sformatf("busy_bit%0d", b), busy, 1);
            if (b == abort_bit) begin
                #2 reset = 1'b1;
                #1;
                check("abort_tx", TX, 1);
                check("abort_busy", busy, 0);
                check("abort_ready", bus.tx_ready, 1);
                check("abort_done", tx_done, 0);
                step();
                reset        = 1'b0;
                bus.tx_valid = 1'b0;
                repeat (3) step();
                check("abort_no_done", done_seen, 0);
                return;
            end
            if (cts_drop && b == 3) CTS = 1'b0;
            repeat (per - 1 - per / 2) step();
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
        end
        if (cts_drop) CTS = 1'b1;
        check("done_pulse", tx_done, 1);
        check("end_tx", TX, 1);
        check("end_busy", busy, 0);
        check("end_ready", bus.tx_ready, 1);
        check("done_count", done_seen, 1);
        check("par_rst_count", par_seen, 1);
        if (!hold) begin
            step();
            check("done_single", tx_done, 0);
        end
    endtask

    // Stray ticks with nothing to send must leave the line idle.
    task automatic idle_ticks();
        bus.tx_valid = 1'b0;
        done_seen = 0;
        par_seen  = 0;
        repeat (5) begin
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            step();
        end
        check("idle_tx", TX, 1);
        check("idle_busy", busy, 0);
        check("idle_ready", bus.tx_ready, 1);
        check("idle_no_done", done_seen, 0);
        check("idle_no_par_rst", par_seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_valid      = 1'b0;
        bus.tx_data       = '0;
        bus.parity_enable = 1'b0;
        bus.parity_type   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.tx_ready, 1);
        check("rst_done", tx_done, 0);
        check("rst_par_rst", phase_accum_reset, 0);
        reset = 1'b0;
        step();

        // Nominal baud: 0x65 without parity, then even and odd parity.
        send_frame(8'h65, 1'b0, 1'b0, 1085, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'h65, 1'b1, PARITY_EVEN, 16, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'h65, 1'b1, PARITY_ODD, 16, 1'b0, 1'b0, -1, 1'b0);

        // Back-to-back words with tx_valid held high.
        send_frame(8'hA5, 1'b0, 1'b0, 12, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 12, 1'b0, 1'b0, -1, 1'b0);

        // Stray ticks in idle, and a tick coinciding with accept.
        idle_ticks();
        send_frame(8'hC3, 1'b0, 1'b0, 14, 1'b1, 1'b0, -1, 1'b0);
        send_frame(8'h5E, 1'b1, PARITY_EVEN, 9, 1'b1, 1'b0, -1, 1'b0);

        // Reset during data bit 3 (frame index 4), then a clean frame.
        send_frame(8'hFF, 1'b0, 1'b0, 10, 1'b0, 1'b0, 4, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 10, 1'b0, 1'b0, -1, 1'b0);

`ifdef UART_TX_CTS_EN
        CTS          = 1'b0;
        bus.tx_data  = 8'h5A;
        bus.tx_valid = 1'b1;
        repeat (100) step();
        check("cts_low_ready", bus.tx_ready, 0);
        check("cts_low_tx", TX, 1);
        check("cts_low_busy", busy, 0);
        CTS = 1'b1;
        send_frame(8'h5A, 1'b1, PARITY_ODD, 11, 1'b0, 1'b0, -1, 1'b1);
`else
        CTS = 1'b0;
        step();
        check("cts_ignored_ready", bus.tx_ready, 1);
        send_frame(8'h5A, 1'b1, PARITY_ODD, 11, 1'b0, 1'b0, -1, 1'b0);
        CTS = 1'b1;
`endif

        // Randomized frames.
        for (int i = 0; i < 20; i++) begin
            send_frame(W'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(24, 4)), 1'($urandom),
                       (i < 19) ? 1'($urandom) : 1'b0, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; companion to uart_rx, with the same frame format and the same shared baud-tick scheme.
- Accepts a parallel word over a valid/ready handshake and shifts it out on TX, LSB first.
- Frame: 1 start bit, UART_SIZE data bits, optional parity bit, 1 stop bit.
- Bit timing comes from an external baud_tick pulse; the block pulses phase_accum_reset at frame start so bit periods align to the start edge.

Parameters:
UART_SIZE, 8, data bits per frame (5..9 supported)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
baud_tick  input  1  single-cycle pulse marking the end of one bit period
phase_accum_reset  output  1  single-cycle pulse restarting the baud phase accumulator
tx_data  input  UART_SIZE  word to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word this cycle
parity_enable  input  1  1 = insert parity bit
parity_type  input  1  0 = odd, 1 = even
CTS  input  1  peer clear-to-send, active-high
TX  output  1  serial line; idles high
busy  output  1  frame in progress
tx_done  output  1  single-cycle pulse when the stop bit completes

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high. Reset forces TX=1, tx_ready=1, busy=0, tx_done=0, phase_accum_reset=0, state IDLE, shift register and bit counter cleared.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - tx_ready = 1 (gated by CTS when UART_TX_CTS_EN is defined).
  - Accept occurs on tx_valid && tx_ready at a clk edge. That edge:
    - latches tx_data into the shift register;
    - samples parity_enable and parity_type into internal registers (later changes are ignored until the next frame);
    - computes parity: even => ^tx_data, odd => ~^tx_data;
    - goes to START, drives TX=0, busy=1, tx_ready=0;
    - drives phase_accum_reset=1 for exactly one cycle.
  - A baud_tick in IDLE or in the accept cycle is ignored.
- START: on baud_tick -> DATA. TX = shift[0]. Bit counter = 0.
- DATA, on each baud_tick:
  - If counter < UART_SIZE-1: shift right, TX = next bit, counter+1.
  - If counter == UART_SIZE-1: go to PARITY (TX = parity) when parity is enabled, else to STOP (TX = 1).
  - Counter width is $clog2(UART_SIZE), with no wrap beyond UART_SIZE-1.
- PARITY: on baud_tick -> STOP, TX=1.
- STOP: on baud_tick -> IDLE. tx_done=1 for one cycle, busy=0, tx_ready=1.
- Frame length: exactly 2 + UART_SIZE + parity_enable baud_tick periods after the accept edge.
- Back-to-back: a word may be accepted in the cycle after tx_done. There is no idle bit beyond the stop bit.
- tx_valid is ignored while busy. The data word is never modified mid-frame.
- Reset mid-frame: the frame is aborted immediately, TX returns high, and no tx_done is issued.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- Defined: tx_ready = (state==IDLE) && CTS, so a frame starts only while CTS=1. CTS dropping mid-frame does not stop the current frame.
- Not defined: CTS is ignored and tx_ready = (state==IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PARITY_ODD=1'b0, PARITY_EVEN=1'b1;
  - function uart_parity(data, type), reused by uart_rx.
- No sub-module. The single FSM plus shift register stays in uart_tx.

Test Plan:
- Parity off, send 8'h65 with one baud_tick every 1085 clks -> TX per bit period: 0,1,0,1,0,0,1,1,0,1. tx_done pulses once after the 10th tick. phase_accum_reset pulses once, on the accept edge.
- parity_enable=1, parity_type=1 (even), send 8'h65 -> parity bit 0, 11-bit frame. Same with parity_type=0 (odd) -> parity bit 1.
- Two words 8'hA5 then 8'h3C with tx_valid held high -> second start bit begins the cycle after the first tx_done. Both frames are correct with no gap.
- With UART_TX_CTS_EN defined:
  - CTS=0 with tx_valid=1 -> tx_ready=0 and TX stays 1 indefinitely.
  - CTS->1 -> accept on the next edge and a normal frame follows.
  - CTS->0 mid-frame -> the frame still completes.
- Assert reset during data bit 3 of 8'hFF -> TX=1 immediately (asynchronous), busy=0, tx_ready=1, no tx_done. The next frame, 8'h00, transmits correctly.
- baud_tick asserted in the same cycle as accept, and spurious ticks in IDLE -> ignored. Start bit lasts a full period until the next tick.
